// File: rtl/axi_rd_arbiter2.sv
// axi_rd_arbiter2: two-master round-robin AXI4 read arbiter, one transaction per grant, with R-stall watchdog
module axi_rd_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADDR_W-1:0]   m_araddr,
  input  logic [15:0]           m_arlen,
  input  logic [1:0]            m_arvalid,
  output logic [1:0]            m_arready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic [1:0]            m_rvalid,
  input  logic [1:0]            m_rready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [7:0]            s_arlen,
  output logic [3:0]            s_arid,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  err_timeout
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  localparam int WD_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  logic [1:0] state;
  logic grant, last_grant, win, sel, adr, dat, ar_hs, r_end;
  logic [WD_W-1:0] wdog, wdog_nxt;
  // IDLE presents master 0 on the AR mux regardless of the stale grant
  always_comb begin
    adr = state == ADDR;
    dat = state == DATA;
    sel = state == IDLE ? 1'b0 : grant;
    win = &m_arvalid ? ~last_grant : m_arvalid[1];
    s_araddr = sel ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    s_arlen = sel ? m_arlen[15:8] : m_arlen[7:0];
    s_arid = {3'b0, sel};
    s_arvalid = adr & m_arvalid[grant];
    m_arready = {2{adr & s_arready}} & {grant, ~grant};
    m_rvalid = {2{dat & s_rvalid}} & {grant, ~grant};
    s_rready = dat & m_rready[grant];
    m_rdata = s_rdata;
    m_rresp = s_rresp;
    m_rlast = s_rlast;
    ar_hs = s_arvalid & s_arready;
    r_end = dat & s_rvalid & s_rready & s_rlast;
    wdog_nxt = (!dat || s_rvalid) ? '0 : (wdog == WD_MAX ? wdog : wdog + 1'b1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      wdog <= '0;
      err_timeout <= 1'b0;
    end else begin
      wdog <= wdog_nxt;
      err_timeout <= err_timeout | (TIMEOUT != 0 && wdog_nxt == WD_MAX);
      if (state == IDLE && |m_arvalid) begin
        state <= ADDR;
        grant <= win;
      end
      if (ar_hs) state <= DATA;
      if (r_end) begin
        state <= IDLE;
        last_grant <= grant;
      end
    end
endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// tb_axi_rd_arbiter2: randomized transaction-level check of the read arbiter against a round-robin reference
module tb_axi_rd_arbiter2;
  logic clk = 0, rst = 1;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [1:0] m_arvalid, m_arready, m_rresp, m_rvalid, m_rready, s_rresp;
  logic [31:0] m_rdata, s_araddr, s_rdata;
  logic m_rlast, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, err_timeout;
  logic [7:0] s_arlen;
  logic [3:0] s_arid;
  int n_tests = 0, n_fail = 0;
  int last_m = 1;
  logic [1:0] held = 0;
  bit err_exp = 0;

  axi_rd_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arid(s_arid), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one whole transaction: expected winner comes from the round-robin rule, beats from arlen+1
  task automatic txn(input logic [1:0] req, input int ar_stall, input int r_stall,
                     input int rr_stall, input int rst_at);
    int w, len, beats, cyc, idle_run;
    logic rv, rr;
    logic [31:0] a;
    w = (req == 2'b11) ? 1 - last_m : (req[1] ? 1 : 0);
    len = w ? int'(m_arlen[15:8]) : int'(m_arlen[7:0]);
    a = w ? m_araddr[63:32] : m_araddr[31:0];
    m_arvalid = req;
    #1;
    check("idle_arvalid", s_arvalid, 0);
    check("idle_arready", m_arready, 0);
    check("idle_arid", s_arid, 0);
    check("idle_err", err_timeout, err_exp);
    step();
    for (int i = 0; i < ar_stall; i++) begin
      s_arready = 0;
      #1;
      check("ar_stall_arvalid", s_arvalid, 1);
      check("ar_stall_arready", m_arready, 0);
      step();
    end
    s_arready = 1;
    #1;
    check("ar_valid", s_arvalid, 1);
    check("ar_id", s_arid, w);
    check("ar_addr", s_araddr, a);
    check("ar_len", s_arlen, len);
    check("ar_ready", m_arready, w ? 2'b10 : 2'b01);
    check("ar_rvalid", m_rvalid, 0);
    step();
    s_arready = 0;
    m_arvalid[w] = 0;
    beats = 0;
    cyc = 0;
    idle_run = 0;
    while (beats <= len && cyc < 300) begin
      if (beats == rst_at) begin
        s_rvalid = 1;
        m_rready = 2'b11;
        rst = 1;
        #1;
        check("rst_rvalid", m_rvalid, 0);
        check("rst_rready", s_rready, 0);
        check("rst_arvalid", s_arvalid, 0);
        check("rst_arready", m_arready, 0);
        check("rst_err", err_timeout, 0);
        step();
        rst = 0;
        s_rvalid = 0;
        m_arvalid = 0;
        last_m = 1;
        err_exp = 0;
        held = 0;
        return;
      end
      rv = r_stall > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (r_stall > 0) r_stall--;
      rr = (beats == 1 && rr_stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (beats == 1 && rr_stall > 0) rr_stall--;
      s_rvalid = rv;
      s_rdata = $urandom;
      s_rresp = 2'($urandom);
      s_rlast = beats == len;
      m_rready[w] = rr;
      m_rready[1-w] = 1'($urandom);
      if (idle_run >= 8) err_exp = 1;
      #1;
      check("r_valid", m_rvalid, w ? {rv, 1'b0} : {1'b0, rv});
      check("r_ready", s_rready, rr);
      check("r_data", m_rdata, s_rdata);
      check("r_resp", m_rresp, s_rresp);
      check("r_last", m_rlast, s_rlast);
      check("r_err", err_timeout, err_exp);
      if (rv && rr) beats++;
      idle_run = rv ? 0 : idle_run + 1;
      step();
      cyc++;
    end
    s_rvalid = 0;
    s_rlast = 0;
    check("beats", beats, len + 1);
    last_m = w;
    held = req & ~(w ? 2'b10 : 2'b01);
  endtask

  initial begin
    int w_seq[6];
    logic [1:0] req;
    m_araddr = {32'h5555_0000, 32'ha000_0048};
    m_arlen = 0;
    m_arvalid = 0;
    m_rready = 0;
    s_arready = 0;
    s_rdata = 0;
    s_rresp = 0;
    s_rlast = 0;
    s_rvalid = 0;
    #1;
    s_arready = 1;
    s_rvalid = 1;
    m_arvalid = 2'b11;
    m_rready = 2'b11;
    #1;
    check("reset_arvalid", s_arvalid, 0);
    check("reset_rready", s_rready, 0);
    check("reset_arready", m_arready, 0);
    check("reset_rvalid", m_rvalid, 0);
    check("reset_arid", s_arid, 0);
    check("reset_addr", s_araddr, 32'ha000_0048);
    check("reset_err", err_timeout, 0);
    m_arvalid = 0;
    s_rvalid = 0;
    m_rready = 0;
    s_arready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    txn(2'b01, 0, 0, 0, -1);
    m_arlen[15:8] = 3;
    txn(2'b10, 0, 0, 2, -1);
    for (int i = 0; i < 6; i++) begin
      txn(2'b11, 0, 0, 0, -1);
      w_seq[i] = last_m;
    end
    for (int i = 0; i < 6; i++) check("fair_seq", w_seq[i], i % 2);
    txn(held | 2'b01, 5, 20, 0, -1);
    check("err_sticky", err_timeout, 1);
    txn(2'b11, 0, 0, 0, 2);
    txn(2'b11, 0, 0, 0, -1);
    check("post_reset_grant", last_m, 0);
    for (int n = 0; n < 40; n++) begin
      if (!held[0]) begin
        m_araddr[31:0] = $urandom;
        m_arlen[7:0] = 8'($urandom_range(0, 3));
      end
      if (!held[1]) begin
        m_araddr[63:32] = $urandom;
        m_arlen[15:8] = 8'($urandom_range(0, 3));
      end
      req = held | 2'($urandom_range(1, 3));
      txn(req, $urandom_range(0, 3), $urandom_range(0, 2), 0, -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
